// File: rtl/lfsr_sched.sv
// Two-requester scheduler for a shared LFSR stepping engine.
// Build option: LFSR_SCHED_FIXED_PRIO_EN selects fixed priority instead of round-robin.
//
// state   | meaning
// IDLE    | waiting for a request, arbitrates and accepts
// LOAD    | one-cycle seed load into the datapath
// STEP    | one step strobe per cycle until the count runs out
// CAPTURE | register the final datapath state
// RESP    | present response to the owner until it is taken
module lfsr_sched #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [1:0]           req_valid,
    output logic [1:0]           req_ready,
    input  logic [2*WIDTH-1:0]   req_seed,
    input  logic [2*CNT_W-1:0]   req_steps,
    output logic [1:0]           rsp_valid,
    input  logic [1:0]           rsp_ready,
    output logic [WIDTH-1:0]     rsp_data,
    output logic                 busy,
    output logic                 lfsr_load,
    output logic [WIDTH-1:0]     lfsr_seed,
    output logic                 lfsr_step,
    input  logic [WIDTH-1:0]     lfsr_state
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LOAD    = 3'd1,
        S_STEP    = 3'd2,
        S_CAPTURE = 3'd3,
        S_RESP    = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   seed_q, seed_d;
    logic [CNT_W-1:0]   steps_q, steps_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               owner_q, owner_d;
    logic [WIDTH-1:0]   rsp_data_q, rsp_data_d;
    logic               grant;
    logic               accept;

`ifdef LFSR_SCHED_FIXED_PRIO_EN
    always_comb begin
        grant = ~req_valid[0];
    end
`else
    logic last_grant_q, last_grant_d;

    // Contention goes to whoever was not served last; a lone requester always wins.
    always_comb begin
        if (&req_valid) begin
            grant = ~last_grant_q;
        end else begin
            grant = ~req_valid[0];
        end
    end
`endif

    assign accept = (state_q == S_IDLE) && (|req_valid);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            seed_q       <= '0;
            steps_q      <= '0;
            cnt_q        <= '0;
            owner_q      <= 1'b0;
            rsp_data_q   <= '0;
`ifndef LFSR_SCHED_FIXED_PRIO_EN
            last_grant_q <= 1'b1;
`endif
        end else begin
            state_q      <= state_d;
            seed_q       <= seed_d;
            steps_q      <= steps_d;
            cnt_q        <= cnt_d;
            owner_q      <= owner_d;
            rsp_data_q   <= rsp_data_d;
`ifndef LFSR_SCHED_FIXED_PRIO_EN
            last_grant_q <= last_grant_d;
`endif
        end
    end

    always_comb begin
        state_d      = state_q;
        seed_d       = seed_q;
        steps_d      = steps_q;
        cnt_d        = cnt_q;
        owner_d      = owner_q;
        rsp_data_d   = rsp_data_q;
`ifndef LFSR_SCHED_FIXED_PRIO_EN
        last_grant_d = last_grant_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    seed_d  = grant ? req_seed[WIDTH +: WIDTH] : req_seed[0 +: WIDTH];
                    steps_d = grant ? req_steps[CNT_W +: CNT_W] : req_steps[0 +: CNT_W];
                    owner_d = grant;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                if (steps_q == '0) begin
                    state_d = S_CAPTURE;
                end else begin
                    cnt_d   = steps_q;
                    state_d = S_STEP;
                end
            end
            S_STEP: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = S_CAPTURE;
                end
            end
            S_CAPTURE: begin
                rsp_data_d = lfsr_state;
                state_d    = S_RESP;
            end
            S_RESP: begin
                if (rsp_ready[owner_q]) begin
`ifndef LFSR_SCHED_FIXED_PRIO_EN
                    last_grant_d = owner_q;
`endif
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // req_ready is gated by reset so a held request is not shown as accepted during reset.
    always_comb begin
        req_ready = 2'b00;
        rsp_valid = 2'b00;
        if (accept && rst_n) begin
            req_ready[grant] = 1'b1;
        end
        if (state_q == S_RESP) begin
            rsp_valid[owner_q] = 1'b1;
        end
        busy      = (state_q != S_IDLE);
        lfsr_load = (state_q == S_LOAD);
        lfsr_step = (state_q == S_STEP);
        lfsr_seed = seed_q;
        rsp_data  = rsp_data_q;
    end

endmodule
